// File: rtl/fmap_window_gen.sv
// Streams one feature map from BRAM in raster order, once per filter pass, and
// builds 3x3 stride-1 windows (no padding) using two line buffers.
module fmap_window_gen #(
  parameter int M        = 8,
  parameter int W        = 8,
  parameter int H        = 8,
  parameter int NUM_PASS = 8,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              start,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [M-1:0]      rd_data,
  output logic              win_valid,
  output logic [9*M-1:0]    win_data,
  output logic              fmap_finish,
  output logic [7:0]        pass_cnt,
  output logic              done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * H - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(W - 1);
  localparam logic [7:0]        LAST_PASS = 8'(NUM_PASS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [CW-1:0]     col_reg;
  logic [RW-1:0]     row_reg;
  logic [7:0]        pass_reg;

  // Position tag of the pixel whose data is on rd_data this cycle.
  logic              pix_vld_reg;
  logic [CW-1:0]     pix_col_reg;
  logic [RW-1:0]     pix_row_reg;

  logic [M-1:0]      line0 [W];
  logic [M-1:0]      line1 [W];

  logic [9*M-1:0]    win_sh_reg;
  logic [9*M-1:0]    win_next;
  logic [9*M-1:0]    win_data_reg;
  logic              win_valid_reg;
  logic              win_hit;

  // FSM state register
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    rd_en       = 1'b0;
    fmap_finish = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = READ;
      end
      READ: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (addr_reg == LAST_ADDR) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = FIN;
      end
      FIN: begin
        busy        = 1'b1;
        fmap_finish = 1'b1;
        if (pass_reg != LAST_PASS) begin
          state_next = READ;
        end else begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address, raster position and pass counters
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_reg <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
      pass_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          addr_reg <= '0;
          col_reg  <= '0;
          row_reg  <= '0;
          pass_reg <= '0;
        end
        READ: begin
          if (addr_reg != LAST_ADDR) begin
            addr_reg <= addr_reg + 1'b1;
            if (col_reg == LAST_COL) begin
              col_reg <= '0;
              row_reg <= row_reg + 1'b1;
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        FIN: begin
          addr_reg <= '0;
          col_reg  <= '0;
          row_reg  <= '0;
          if (pass_reg != LAST_PASS) pass_reg <= pass_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pix_vld_reg <= 1'b0;
      pix_col_reg <= '0;
      pix_row_reg <= '0;
    end else begin
      pix_vld_reg <= (state_reg == READ);
      pix_col_reg <= col_reg;
      pix_row_reg <= row_reg;
    end
  end

  // Line buffers carry no reset: rows 0 and 1 overwrite them before any use.
  always_ff @(posedge clk) begin
    if (pix_vld_reg) begin
      line1[pix_col_reg] <= line0[pix_col_reg];
      line0[pix_col_reg] <= rd_data;
    end
  end

  // Next window: shift columns left, right column = rows row-2, row-1, row.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      assign win_next[M*(3*gi+0) +: M] = win_sh_reg[M*(3*gi+1) +: M];
      assign win_next[M*(3*gi+1) +: M] = win_sh_reg[M*(3*gi+2) +: M];
    end
  endgenerate

  assign win_next[M*2 +: M] = line1[pix_col_reg];
  assign win_next[M*5 +: M] = line0[pix_col_reg];
  assign win_next[M*8 +: M] = rd_data;

  assign win_hit = pix_vld_reg && (pix_row_reg >= RW'(2)) && (pix_col_reg >= CW'(2));

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      win_sh_reg    <= '0;
      win_data_reg  <= '0;
      win_valid_reg <= 1'b0;
    end else begin
      win_valid_reg <= win_hit;
      if (pix_vld_reg) win_sh_reg   <= win_next;
      if (win_hit)     win_data_reg <= win_next;
    end
  end

  assign rd_addr   = addr_reg;
  assign pass_cnt  = pass_reg;
  assign win_valid = win_valid_reg;
  assign win_data  = win_data_reg;

endmodule

// File: tb/tb_fmap_window_gen.sv
// Directed bench for fmap_window_gen: expected windows are queued when a run is
// started and popped as the DUT presents them, along with pulse/timing checks.
module tb_fmap_window_gen;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        start4, start3;
  logic        busy4, busy3, rd_en4, rd_en3;
  logic [7:0]  rd_addr4, rd_addr3;
  logic [7:0]  rd_data4, rd_data3;
  logic        wv4, wv3, fin4, fin3, done4, done3;
  logic [71:0] wd4, wd3;
  logic [7:0]  pc4, pc3;

  always #5 clk = ~clk;

  fmap_window_gen #(.M(8), .W(4), .H(4), .NUM_PASS(2), .ADDR_W(8)) dut4 (
    .clk(clk), .Rst_n(Rst_n), .start(start4), .busy(busy4), .rd_en(rd_en4),
    .rd_addr(rd_addr4), .rd_data(rd_data4), .win_valid(wv4), .win_data(wd4),
    .fmap_finish(fin4), .pass_cnt(pc4), .done(done4));

  fmap_window_gen #(.M(8), .W(3), .H(3), .NUM_PASS(1), .ADDR_W(8)) dut3 (
    .clk(clk), .Rst_n(Rst_n), .start(start3), .busy(busy3), .rd_en(rd_en3),
    .rd_addr(rd_addr3), .rd_data(rd_data3), .win_valid(wv3), .win_data(wd3),
    .fmap_finish(fin3), .pass_cnt(pc3), .done(done3));

  // BRAM models: pixel = addr + 1, one cycle read latency
  always @(posedge clk) begin
    if (rd_en4) rd_data4 <= rd_addr4 + 8'd1;
    if (rd_en3) rd_data3 <= rd_addr3 + 8'd1;
  end

  logic        sel;
  logic        wv, fin, dn, bsy;
  logic [71:0] wd;
  always_comb begin
    wv  = sel ? wv3   : wv4;
    fin = sel ? fin3  : fin4;
    dn  = sel ? done3 : done4;
    bsy = sel ? busy3 : busy4;
    wd  = sel ? wd3   : wd4;
  end

  typedef struct {
    int          cyc;
    logic [71:0] data;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc;
  int          fin_a, fin_b, done_c;
  int          nwin;
  logic [71:0] last_win;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mkwin(input int w, input int row, input int col);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[8*(3*r+c) +: 8] = 8'((row - 2 + r) * w + (col - 2 + c) + 1);
    return v;
  endfunction

  task automatic push_run(input int w, input int h, input int np);
    exp_t e;
    for (int p = 0; p < np; p++)
      for (int a = 0; a < w * h; a++)
        if ((a / w) >= 2 && (a % w) >= 2) begin
          e.cyc  = 1 + p * (w * h + 2) + a + 2;
          e.data = mkwin(w, a / w, a % w);
          q.push_back(e);
        end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    chk("fmap_finish", 72'(fin), 72'(cyc == fin_a || cyc == fin_b));
    chk("done", 72'(dn), 72'(cyc == done_c));
    chk("win_expected", 72'(wv), 72'(q.size() != 0 && q[0].cyc == cyc));
    if (wv) begin
      nwin++;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("win_cycle", 72'(cyc), 72'(e.cyc));
        chk("win_data", wd, e.data);
      end
      last_win = wd;
    end else begin
      chk("win_hold", wd, last_win);
    end
    $display("cyc=%0d busy=%0b win_valid=%0b win_data=%h fin=%0b done=%0b",
             cyc, bsy, wv, wd, fin, dn);
  endtask

  initial begin
    sel = 1'b0; start4 = 1'b0; start3 = 1'b0;
    fin_a = -1; fin_b = -1; done_c = -1; nwin = 0; cyc = 0; last_win = '0;
    Rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 72'(busy4), 72'(0));
    chk("rst_rd_en", 72'(rd_en4), 72'(0));
    chk("rst_rd_addr", 72'(rd_addr4), 72'(0));
    chk("rst_win_valid", 72'(wv4), 72'(0));
    chk("rst_win_data", wd4, 72'(0));
    chk("rst_fmap_finish", 72'(fin4), 72'(0));
    chk("rst_pass_cnt", 72'(pc4), 72'(0));
    chk("rst_done", 72'(done4), 72'(0));
    Rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Run aborted by an asynchronous reset in cycle 7
    cyc = 0;
    start4 = 1'b1;
    repeat (7) step();
    start4 = 1'b0;
    chk("pre_rst_busy", 72'(busy4), 72'(1));
    chk("pre_rst_rd_addr", 72'(rd_addr4), 72'(6));
    Rst_n = 1'b0;
    #1;
    chk("arst_busy", 72'(busy4), 72'(0));
    chk("arst_rd_en", 72'(rd_en4), 72'(0));
    chk("arst_rd_addr", 72'(rd_addr4), 72'(0));
    chk("arst_win_valid", 72'(wv4), 72'(0));
    chk("arst_pass_cnt", 72'(pc4), 72'(0));
    @(posedge clk);
    #1;
    Rst_n = 1'b1;
    last_win = '0;
    q.delete();
    @(posedge clk);
    #1;

    // Full two-pass run with start held high throughout
    cyc = 0; nwin = 0;
    start4 = 1'b1;
    push_run(4, 4, 2);
    fin_a = 18; fin_b = 36; done_c = 36;
    while (cyc < 38) begin
      step();
      if (cyc == 1)  chk("busy_c1", 72'(busy4), 72'(1));
      if (cyc == 1)  chk("rd_addr_c1", 72'(rd_addr4), 72'(0));
      if (cyc == 16) chk("rd_addr_c16", 72'(rd_addr4), 72'(15));
      if (cyc == 17) chk("rd_en_drain", 72'(rd_en4), 72'(0));
      if (cyc == 19) chk("rd_addr_c19", 72'(rd_addr4), 72'(0));
      if (cyc == 19) chk("pass_cnt_c19", 72'(pc4), 72'(1));
      if (cyc == 36) chk("busy_c36", 72'(busy4), 72'(1));
      if (cyc == 37) chk("busy_c37", 72'(busy4), 72'(0));
      if (cyc == 38) chk("busy_c38", 72'(busy4), 72'(1));
    end
    chk("win_count", 72'(nwin), 72'(8));
    chk("queue_empty", 72'(q.size()), 72'(0));
    start4 = 1'b0;
    Rst_n = 1'b0;
    @(posedge clk);
    #1;
    Rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3x3 map, single pass: one window in cycle 11
    sel = 1'b1;
    cyc = 0; nwin = 0; last_win = '0;
    start3 = 1'b1;
    push_run(3, 3, 1);
    fin_a = 11; fin_b = -1; done_c = 11;
    step();
    start3 = 1'b0;
    while (cyc < 14) begin
      step();
      if (cyc == 12) chk("busy3_c12", 72'(busy3), 72'(0));
    end
    chk("win3_count", 72'(nwin), 72'(1));
    chk("queue3_empty", 72'(q.size()), 72'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
